// File: rtl/adc_wb_reader.sv
// Wishbone classic initiator for the VCO-ADC register slave: writes one config
// word, polls status and streams samples into a first-word-fall-through FIFO.
module adc_wb_reader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [7:0]  CFG_OFS    = 8'h00,
    parameter logic [7:0]  STAT_OFS   = 8'h04,
    parameter logic [7:0]  DATA_OFS   = 8'h08,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TIMEOUT    = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          start_i,
    input  logic [31:0]                   cfg_word_i,
    input  logic [15:0]                   n_samples_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          timeout_o,
    output logic                          overflow_o,
    output logic                          wbm_cyc_o,
    output logic                          wbm_stb_o,
    output logic                          wbm_we_o,
    output logic [3:0]                    wbm_sel_o,
    output logic [31:0]                   wbm_adr_o,
    output logic [31:0]                   wbm_dat_o,
    input  logic [31:0]                   wbm_dat_i,
    input  logic                          wbm_ack_i,
    input  logic                          fifo_rd_i,
    output logic [31:0]                   fifo_dat_o,
    output logic                          fifo_empty_o,
    output logic                          fifo_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] CFG_ADR  = BASE_ADDR + {24'h00_0000, CFG_OFS};
    localparam logic [31:0] STAT_ADR = BASE_ADDR + {24'h00_0000, STAT_OFS};
    localparam logic [31:0] DATA_ADR = BASE_ADDR + {24'h00_0000, DATA_OFS};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_CFG   = 3'd1,
        S_POLL     = 3'd2,
        S_POLL_GAP = 3'd3,
        S_RD_DATA  = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    state_t          state_r;
    logic [15:0]     n_r;
    logic [15:0]     cnt_r;
    logic [TW-1:0]   to_cnt_r;
    logic            gap_r;
    logic            cyc_r;
    logic            we_r;
    logic [3:0]      sel_r;
    logic [31:0]     adr_r;
    logic [31:0]     dat_r;
    logic            busy_r;
    logic            done_r;
    logic            timeout_r;
    logic            overflow_r;

    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     level_r;

    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            wr_en_s;
    logic            drop_s;

    // A full FIFO still accepts a push when a pop retires the head in the same cycle.
    assign push_s  = (state_r == S_RD_DATA) && cyc_r && wbm_ack_i;
    assign pop_s   = fifo_rd_i && (level_r != '0);
    assign full_s  = (level_r == (AW+1)'(FIFO_DEPTH));
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // Bus sequencer: one bus cycle per state, separated by at least one idle cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r    <= S_IDLE;
            n_r        <= 16'd0;
            cnt_r      <= 16'd0;
            to_cnt_r   <= '0;
            gap_r      <= 1'b0;
            cyc_r      <= 1'b0;
            we_r       <= 1'b0;
            sel_r      <= 4'h0;
            adr_r      <= 32'h0000_0000;
            dat_r      <= 32'h0000_0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        n_r        <= n_samples_i;
                        cnt_r      <= 16'd0;
                        timeout_r  <= 1'b0;
                        overflow_r <= 1'b0;
                        busy_r     <= 1'b1;
                        cyc_r      <= 1'b1;
                        we_r       <= 1'b1;
                        sel_r      <= 4'hF;
                        adr_r      <= CFG_ADR;
                        dat_r      <= cfg_word_i;
                        to_cnt_r   <= '0;
                        state_r    <= S_WR_CFG;
                    end
                end
                S_WR_CFG, S_POLL, S_RD_DATA: begin
                    if (!cyc_r) begin
                        cyc_r    <= 1'b1;
                        we_r     <= 1'b0;
                        sel_r    <= 4'hF;
                        adr_r    <= (state_r == S_POLL) ? STAT_ADR : DATA_ADR;
                        to_cnt_r <= '0;
                    end else if (wbm_ack_i) begin
                        cyc_r <= 1'b0;
                        we_r  <= 1'b0;
                        sel_r <= 4'h0;
                        dat_r <= 32'h0000_0000;
                        if (state_r == S_WR_CFG) begin
                            if (n_r == 16'd0) begin
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= S_DONE;
                            end else begin
                                state_r <= S_POLL;
                            end
                        end else if (state_r == S_POLL) begin
                            if (wbm_dat_i[0]) begin
                                state_r <= S_RD_DATA;
                            end else begin
                                gap_r   <= 1'b0;
                                state_r <= S_POLL_GAP;
                            end
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                            if ((cnt_r + 16'd1) == n_r) begin
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= S_DONE;
                            end else begin
                                state_r <= S_POLL;
                            end
                        end
                    end else if (to_cnt_r == TW'(TIMEOUT - 1)) begin
                        cyc_r     <= 1'b0;
                        we_r      <= 1'b0;
                        sel_r     <= 4'h0;
                        dat_r     <= 32'h0000_0000;
                        timeout_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= S_ERR;
                    end else begin
                        to_cnt_r <= to_cnt_r + TW'(1);
                    end
                end
                S_POLL_GAP: begin
                    if (gap_r) begin
                        state_r <= S_POLL;
                    end else begin
                        gap_r <= 1'b1;
                    end
                end
                S_DONE:  state_r <= S_IDLE;
                S_ERR:   state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en_s) begin
            mem[wr_ptr_r] <= wbm_dat_i;
        end
    end

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign timeout_o    = timeout_r;
    assign overflow_o   = overflow_r;
    assign wbm_cyc_o    = cyc_r;
    assign wbm_stb_o    = cyc_r;
    assign wbm_we_o     = we_r;
    assign wbm_sel_o    = sel_r;
    assign wbm_adr_o    = adr_r;
    assign wbm_dat_o    = dat_r;
    assign fifo_dat_o   = mem[rd_ptr_r];
    assign fifo_empty_o = (level_r == '0);
    assign fifo_full_o  = full_s;
    assign fifo_level_o = level_r;

endmodule
